// File: rtl/binconv_pkg.sv
// Shared constants, FSM state type and popcount helper for the first
// binarized 3x3 convolution layer.
package binconv_pkg;

  localparam int unsigned ISIZE_L = 28;
  localparam int unsigned ISIZE_H = 28;
  localparam int unsigned KSIZE   = 3;
  localparam int unsigned KK      = KSIZE * KSIZE;
  localparam int unsigned OSIZE_L = ISIZE_L - KSIZE + 1;
  localparam int unsigned OSIZE_H = ISIZE_H - KSIZE + 1;
  localparam int unsigned THR_W   = $clog2(KK + 1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic logic [THR_W-1:0] popcount(input logic [KK-1:0] bits);
    logic [THR_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < KK; i++) begin
      cnt = cnt + THR_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/binconv_row_unit.sv
// Combinational XNOR-popcount-threshold for one output row, fed by a
// KSIZE-row slice of the latched image.
module binconv_row_unit
  import binconv_pkg::*;
(
  input  logic [KSIZE*ISIZE_L-1:0] slice,
  input  logic [KK-1:0]            weights,
  input  logic [THR_W-1:0]         thr,
  output logic [OSIZE_L-1:0]       row_bits
);

  for (genvar c = 0; c < OSIZE_L; c++) begin : g_col
    logic [KK-1:0] match;

    for (genvar kr = 0; kr < KSIZE; kr++) begin : g_kr
      for (genvar kc = 0; kc < KSIZE; kc++) begin : g_kc
        assign match[kr*KSIZE+kc] = ~(slice[kr*ISIZE_L+c+kc] ^ weights[kr*KSIZE+kc]);
      end
    end

    // Unsigned compare: thr=0 always fires, thr>KK never does.
    assign row_bits[c] = (popcount(match) >= thr);
  end

endmodule

// File: rtl/binconv1_sign.sv
// Sequential binarized conv layer: snapshots image/weights on start, then
// produces one 26-bit output row per clock into a held result register.
module binconv1_sign
  import binconv_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KK+THR_W-1:0]          g_input,
  input  logic [ISIZE_L*ISIZE_H-1:0]   e_input,
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic [OSIZE_L*OSIZE_H-1:0]   o
);

  localparam int unsigned ROW_W = $clog2(OSIZE_H);
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(OSIZE_H - 1);

  state_e                         state_q, state_d;
  logic [ROW_W-1:0]               row_q, row_d;
  logic [ISIZE_L*ISIZE_H-1:0]     img_q, img_d;
  logic [KK-1:0]                  w_q, w_d;
  logic [THR_W-1:0]               thr_q, thr_d;
  logic [OSIZE_L*OSIZE_H-1:0]     o_q, o_d;
  logic                           done_q, done_d;
  logic                           valid_q, valid_d;

  logic [KSIZE*ISIZE_L-1:0]       slice;
  logic [OSIZE_L-1:0]             row_bits;

  assign slice = img_q[row_q*ISIZE_L +: KSIZE*ISIZE_L];

  binconv_row_unit u_row_unit (
    .slice    (slice),
    .weights  (w_q),
    .thr      (thr_q),
    .row_bits (row_bits)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    img_d   = img_q;
    w_d     = w_q;
    thr_d   = thr_q;
    o_d     = o_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          img_d   = e_input;
          w_d     = g_input[KK-1:0];
          thr_d   = g_input[KK +: THR_W];
          o_d     = '0;
          valid_d = 1'b0;
          row_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        o_d[row_q*OSIZE_L +: OSIZE_L] = row_bits;
        if (row_q == LastRow) begin
          row_d   = '0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      img_q   <= '0;
      w_q     <= '0;
      thr_q   <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      img_q   <= img_d;
      w_q     <= w_d;
      thr_q   <= thr_d;
      o_q     <= o_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = done_q;
  assign valid = valid_q;
  assign o     = o_q;

endmodule

// File: tb/tb_binconv1_sign.sv
// Self-checking bench for binconv1_sign: directed vector table plus
// snapshot, mid-run reset and back-to-back start sequences.
module tb_binconv1_sign;
  import binconv_pkg::*;

  localparam int unsigned IW = ISIZE_L * ISIZE_H;
  localparam int unsigned OW = OSIZE_L * OSIZE_H;
  localparam int unsigned GW = KK + THR_W;

  typedef struct {
    string         name;
    logic [IW-1:0] img;
    logic [GW-1:0] g;
    logic [OW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [GW-1:0] g_input = '0;
  logic [IW-1:0] e_input = '0;
  logic          busy, done, valid;
  logic [OW-1:0] o;

  int total = 0;
  int bad = 0;

  binconv1_sign dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .g_input (g_input),
    .e_input (e_input),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .o       (o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_conv(input logic [IW-1:0] img, input logic [GW-1:0] g);
    logic [OW-1:0] res;
    int m;
    int thr;
    res = '0;
    thr = int'(g[GW-1:KK]);
    for (int r = 0; r < OSIZE_H; r++) begin
      for (int c = 0; c < OSIZE_L; c++) begin
        m = 0;
        for (int kr = 0; kr < KSIZE; kr++) begin
          for (int kc = 0; kc < KSIZE; kc++) begin
            if (img[(r+kr)*ISIZE_L + c + kc] == g[kr*KSIZE + kc]) m++;
          end
        end
        res[r*OSIZE_L + c] = (m >= thr);
      end
    end
    return res;
  endfunction

  function automatic logic [GW-1:0] mk_g(input int thr, input logic [KK-1:0] w);
    return {THR_W'(thr), w};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_run(input logic [IW-1:0] img, input logic [GW-1:0] g);
    e_input = img;
    g_input = g;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!done && n < 100);
  endtask

  vec_t vecs[6];
  int   n;
  int   ndone;
  int   first_done;
  logic [IW-1:0] img_a, img_b;
  logic [GW-1:0] g_h;
  logic [OW-1:0] exp_px;

  initial begin
    logic [IW-1:0] img_px;
    img_px = '0;
    img_px[5*ISIZE_L + 7] = 1'b1;
    exp_px = '0;
    exp_px[4*OSIZE_L + 6] = 1'b1;

    vecs[0] = '{"zero_img_zero_w_thr9", '0, mk_g(9, 9'h000), '1};
    vecs[1] = '{"zero_img_ones_w_thr1", '0, mk_g(1, 9'h1FF), '0};
    vecs[2] = '{"zero_img_ones_w_thr0", '0, mk_g(0, 9'h1FF), '1};
    vecs[3] = '{"zero_img_zero_w_thr15", '0, mk_g(15, 9'h000), '0};
    vecs[4] = '{"single_pixel_thr9", img_px, mk_g(9, 9'h010), exp_px};
    vecs[5] = '{"ones_img_zero_w_thr1", '1, mk_g(1, 9'h000), '0};

    // Reset state
    #12;
    check("rst_o", o, '0);
    check("rst_busy", OW'(busy), '0);
    check("rst_done", OW'(done), '0);
    check("rst_valid", OW'(valid), '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_run(vecs[i].img, vecs[i].g);
      check({vecs[i].name, "_busy"}, OW'(busy), OW'(1));
      check({vecs[i].name, "_valid_low"}, OW'(valid), OW'(0));
      wait_done(n);
      check({vecs[i].name, "_latency"}, OW'(n), OW'(26));
      check({vecs[i].name, "_valid"}, OW'(valid), OW'(1));
      check({vecs[i].name, "_busy_off"}, OW'(busy), OW'(0));
      check({vecs[i].name, "_o"}, o, vecs[i].exp);
      @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, "_done_clr"}, OW'(done), OW'(0));
      check({vecs[i].name, "_hold"}, o, vecs[i].exp);
    end

    // Inputs change and start toggles during RUN: snapshot rules.
    start_run(img_px, mk_g(9, 9'h010));
    e_input = '1;
    g_input = mk_g(0, 9'h1FF);
    n = 0;
    ndone = 0;
    first_done = 0;
    while (n < 32) begin
      start = (n < 20) ? n[0] : 1'b0;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = n;
      end
    end
    start = 1'b0;
    check("snap_latency", OW'(first_done), OW'(26));
    check("snap_done_once", OW'(ndone), OW'(1));
    check("snap_o", o, exp_px);
    check("snap_valid", OW'(valid), OW'(1));

    // Reset mid-run at cycle 10.
    start_run('0, mk_g(9, 9'h000));
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    check("arst_o", o, '0);
    check("arst_valid", OW'(valid), OW'(0));
    check("arst_busy", OW'(busy), OW'(0));
    check("arst_done", OW'(done), OW'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_run(img_px, mk_g(9, 9'h010));
    wait_done(n);
    check("post_rst_latency", OW'(n), OW'(26));
    check("post_rst_o", o, exp_px);
    @(negedge clk);

    // start held high across two runs.
    for (int i = 0; i < int'(IW); i++) begin
      img_a[i] = 1'($urandom_range(0, 1));
      img_b[i] = 1'($urandom_range(0, 1));
    end
    g_h = mk_g(5, 9'($urandom_range(0, 511)));
    e_input = img_a;
    g_input = g_h;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e_input = img_b;
    wait_done(n);
    check("b2b_latency_a", OW'(n), OW'(26));
    check("b2b_o_a", o, ref_conv(img_a, g_h));
    @(posedge clk);
    @(negedge clk);
    check("b2b_restart_valid", OW'(valid), OW'(0));
    check("b2b_restart_busy", OW'(busy), OW'(1));
    check("b2b_restart_done", OW'(done), OW'(0));
    start = 1'b0;
    wait_done(n);
    check("b2b_latency_b", OW'(n), OW'(26));
    check("b2b_o_b", o, ref_conv(img_b, g_h));
    check("b2b_valid_b", OW'(valid), OW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binconv1_sign.md
Name: binconv1_sign

Overview:
- First binarized layer: 3x3 single-channel XNOR-popcount convolution with sign (threshold) activation on a flattened binary image.
- Produces the flattened 26x26 bitmap consumed directly by the downstream 2x2 OR-maxpool stage.
- Sequential: one output row per clock, start/done handshake, result held stable for the pooling stage.

Parameters:
- ISIZE_L, 28, input image width (pixels per row).
- ISIZE_H, 28, input image height (rows).
- KSIZE, 3, square kernel size; OSIZE_L = ISIZE_L-KSIZE+1, OSIZE_H = ISIZE_H-KSIZE+1 (26x26 by default), no padding, stride 1.
- THR_W, $clog2(KSIZE*KSIZE+1), threshold width (4 by default).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin conversion; sampled only in IDLE.
- g_input  input  KSIZE*KSIZE+THR_W  garbler side: bits [KSIZE*KSIZE-1:0] weights w[kr*KSIZE+kc]; upper THR_W bits threshold thr.
- e_input  input  ISIZE_L*ISIZE_H  evaluator side: binary image, flattened row-major, pixel (r,c) at bit r*ISIZE_L+c.
- busy  output  1  high while RUN.
- done  output  1  one-cycle pulse when last row written.
- valid  output  1  o holds a complete result.
- o  output  OSIZE_L*OSIZE_H  flattened row-major result, bit r*OSIZE_L+c; feeds maxpool g_input.

Behaviour:
- Reset (rst low, async): state IDLE, row counter 0, o all zero, busy 0, done 0, valid 0, latched image/weights/thr zero. Reset mid-RUN aborts; no partial result survives.
- Per output pixel (r,c): m = popcount over kr,kc of ~(e_input[(r+kr)*ISIZE_L+c+kc] ^ w[kr*KSIZE+kc]); range 0..KSIZE*KSIZE. o bit = (m >= thr), unsigned compare. thr=0 gives 1 everywhere; thr > KSIZE*KSIZE gives 0 everywhere.
- FSM states: IDLE, RUN.
- IDLE: on edge with start=1, snapshot e_input, weights and thr into internal registers, clear o, valid<=0, row<=0, busy<=1, go RUN. Inputs may change afterwards without effect.
- RUN: each edge writes all OSIZE_L bits of output row `row` from the snapshot, row<=row+1. On the edge writing row OSIZE_H-1: done<=1, valid<=1, busy<=0, row<=0, go IDLE.
- Latency: start sampled at edge E0; rows 0..25 written at E1..E26; done high for exactly the cycle after E26 and cleared at E27.
- start during RUN is ignored, with no queuing. start held high continuously in IDLE starts a new run immediately after done, and valid drops again at that start edge.
- valid stays high and o stays stable from done until the next accepted start or reset.
- Row counter width $clog2(OSIZE_H); it never exceeds OSIZE_H-1.

Decomposition:
- Shared package binconv_pkg: derived constants OSIZE_L/OSIZE_H, THR_W, state enum type, popcount function (KSIZE*KSIZE bits to THR_W bits).
- One combinational sub-module binconv_row_unit: takes a KSIZE-row image slice (KSIZE*ISIZE_L bits), weights and thr, and returns one OSIZE_L-bit output row. The top module holds the FSM, counter, snapshot registers and output register.

Test Plan:
- All-zero image, all-zero weights, thr=9, pulse start: busy for 26 cycles, done pulses at E26, valid=1, o = all 676 ones.
- All-zero image, all-ones weights, thr=1: o = all zeros; thr=0 on a rerun gives all ones; thr=15 gives all zeros.
- Weights = only w[4]=1, image all zero except pixel (5,7), thr=9: o bit 110 (4*26+6) is the only 1.
- Change e_input and g_input on the cycle after start, and assert start repeatedly during RUN: result matches the snapshot, done pulses once, and the run still takes exactly 26 cycles.
- Drop rst low at cycle 10 of RUN: o=0, valid=0, busy=0, done=0 immediately (async). After release, a fresh start completes normally.
- Hold start high across two runs: second run begins at the edge after done, valid deasserts, and both results are checked against a reference model.
